// File: rtl/demux_8x1.sv
// 1-to-8 registered demultiplexer: routes `a` to the output chosen by `sel`
// and clears the other seven outputs every cycle.
module demux_8x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7
);

    // Unknown select codes decode to no output, so X/Z on sel yields all zeros.
    function automatic logic [7:0] decode_sel(input logic [2:0] s);
        logic [7:0] onehot;
        case (s)
            3'd0:    onehot = 8'b0000_0001;
            3'd1:    onehot = 8'b0000_0010;
            3'd2:    onehot = 8'b0000_0100;
            3'd3:    onehot = 8'b0000_1000;
            3'd4:    onehot = 8'b0001_0000;
            3'd5:    onehot = 8'b0010_0000;
            3'd6:    onehot = 8'b0100_0000;
            3'd7:    onehot = 8'b1000_0000;
            default: onehot = 8'b0000_0000;
        endcase
        return onehot;
    endfunction

    logic [7:0]       dec_s;
    logic [WIDTH-1:0] data_s [8];
    logic [WIDTH-1:0] y_r    [8];

    // Gate the data input with each decode bit to form the next output values.
    always_comb begin
        dec_s = decode_sel(sel);
        for (int i = 0; i < 8; i++) begin
            data_s[i] = a & {WIDTH{dec_s[i]}};
        end
    end

    // Output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                y_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                y_r[i] <= data_s[i];
            end
        end
    end

    assign y0 = y_r[0];
    assign y1 = y_r[1];
    assign y2 = y_r[2];
    assign y3 = y_r[3];
    assign y4 = y_r[4];
    assign y5 = y_r[5];
    assign y6 = y_r[6];
    assign y7 = y_r[7];

endmodule

// File: tb/tb_demux_8x1.sv
// Scoreboard bench for demux_8x1: a 1-bit and an 8-bit instance driven in
// lockstep, expected output patterns queued at drive time and checked after each edge.
module tb_demux_8x1;

    typedef struct {
        string       tag;
        logic [7:0]  exp_n;
        logic [63:0] exp_w;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [0:0]  a_n;
    logic [7:0]  a_w;
    logic [2:0]  sel;
    logic [0:0]  n0, n1, n2, n3, n4, n5, n6, n7;
    logic [7:0]  w0, w1, w2, w3, w4, w5, w6, w7;
    logic [7:0]  y_n;
    logic [63:0] y_w;

    int   checks_cnt;
    int   errors_cnt;
    exp_t exp_q[$];

    demux_8x1 #(.WIDTH(1)) dut_n (
        .clk(clk), .rst(rst), .a(a_n), .sel(sel),
        .y0(n0), .y1(n1), .y2(n2), .y3(n3),
        .y4(n4), .y5(n5), .y6(n6), .y7(n7)
    );

    demux_8x1 #(.WIDTH(8)) dut_w (
        .clk(clk), .rst(rst), .a(a_w), .sel(sel),
        .y0(w0), .y1(w1), .y2(w2), .y3(w3),
        .y4(w4), .y5(w5), .y6(w6), .y7(w7)
    );

    assign y_n = {n7, n6, n5, n4, n3, n2, n1, n0};
    assign y_w = {w7, w6, w5, w4, w3, w2, w1, w0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one transaction at the falling edge, queue its expectation, and
    // check the registered outputs just after the following rising edge.
    task automatic step(input string tag, input logic [7:0] av, input logic [2:0] s);
        exp_t e;
        @(negedge clk);
        a_n = av[0:0];
        a_w = av;
        sel = s;
        e.tag   = tag;
        e.exp_n = 8'(av[0]) << s;
        e.exp_w = 64'(av) << (8 * s);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_n"}, {56'd0, y_n}, {56'd0, e.exp_n});
            check({e.tag, "_w"}, y_w, e.exp_w);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        a_n = 1'b1;
        a_w = 8'hFF;
        sel = 3'd5;

        // Reset held while clocking with live data
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_n", {56'd0, y_n}, 64'd0);
            check("rst_hold_w", y_w, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        step("rst_release", 8'hFF, 3'd5);

        // Sweep select with nonzero data
        for (int s = 0; s < 8; s++) begin
            step("sweep", 8'(8'h11 * (s + 1)) | 8'h01, 3'(s));
        end

        // Zero data on every select
        for (int s = 0; s < 8; s++) begin
            step("zero", 8'h00, 3'(s));
        end

        // Back-to-back select changes
        step("b2b_sel2", 8'h3C, 3'd2);
        step("b2b_sel6", 8'hC3, 3'd6);

        // Async reset pulsed between edges
        step("pre_async", 8'h5A, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_n", {56'd0, y_n}, 64'd0);
        check("async_w", y_w, 64'd0);
        #1;
        rst = 1'b0;
        step("post_async", 8'h5A, 3'd3);

        // Width case
        step("width_a5", 8'hA5, 3'd7);

        // Random traffic
        for (int i = 0; i < 20; i++) begin
            step("rand", 8'($urandom_range(255, 0)), 3'($urandom_range(7, 0)));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
